// File: rtl/sub_top.sv
// ============================================================================
// sub_top: registered WIDTH-bit two's-complement subtractor with signed overflow (rev 1.0)
// ============================================================================
`default_nettype none

module sub_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module sub_top #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             overflow
);
  logic [WIDTH-1:0] w_b_n;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH:0]   w_carry;
  logic             w_ovf;

  // a - b = a + ~b + 1: seed the ripple chain with a carry-in of 1
  assign w_b_n      = ~b;
  assign w_carry[0] = 1'b1;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
      sub_fa u_fa (
        .x  (a[i]),
        .y  (w_b_n[i]),
        .ci (w_carry[i]),
        .s  (w_sum[i]),
        .co (w_carry[i+1])
      );
    end
  endgenerate

  // Signed overflow: carry into the sign bit disagrees with carry out of it
  assign w_ovf = w_carry[WIDTH-1] ^ w_carry[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      out      <= '0;
      overflow <= 1'b0;
    end else begin
      out      <= w_sum;
      overflow <= w_ovf;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_sub_top.sv
// Self-checking bench for sub_top: directed corners, exhaustive sweep, random pairs.
`default_nettype none

module tb_sub_top;
  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] a   = '0;
  logic [W-1:0] b   = '0;
  logic [W-1:0] out;
  logic         overflow;

  int passed = 0;
  int total  = 0;

  sub_top #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .out      (out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Reference: exact integer difference, overflow iff outside the signed range
  function automatic logic [W:0] model(input logic signed [W-1:0] av, input logic signed [W-1:0] bv);
    int d;
    logic ov;
    d  = int'(av) - int'(bv);
    ov = (d < -(1 << (W-1))) || (d > (1 << (W-1)) - 1);
    return {ov, d[W-1:0]};
  endfunction

  task automatic step(input logic r, input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    rst = r;
    a   = av;
    b   = bv;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] eo, input logic eov);
    total++;
    assert (out === eo && overflow === eov) passed++;
    else $error("FAIL %s: out=%0d ovf=%b, expected out=%0d ovf=%b (a=%0d b=%0d)",
                tag, $signed(out), overflow, $signed(eo), eov, $signed(a), $signed(b));
  endtask

  task automatic run_model(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [W:0] e;
    step(1'b0, av, bv);
    e = model(av, bv);
    check(tag, e[W-1:0], e[W]);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    // Reset held for two edges with live operands
    step(1'b1, 6'd5, 6'd3);
    check("reset_edge1", 6'd0, 1'b0);
    step(1'b1, 6'd5, 6'd3);
    check("reset_edge2", 6'd0, 1'b0);
    step(1'b0, 6'd5, 6'd3);
    check("reset_release", 6'd2, 1'b0);

    // Directed corners with hand-derived results
    step(1'b0, 6'b100000, 6'd1);      check("min_minus_1",   6'b011111, 1'b1);
    step(1'b0, 6'd31, 6'b111111);     check("max_minus_m1",  6'b100000, 1'b1);
    step(1'b0, 6'b100000, 6'b100000); check("min_minus_min", 6'd0,      1'b0);
    step(1'b0, 6'd0, 6'd31);          check("zero_minus_max",6'b100001, 1'b0);
    step(1'b0, 6'b111111, 6'd31);     check("m1_minus_max",  6'b100000, 1'b0);
    step(1'b0, 6'd0, 6'b100000);      check("zero_minus_min",6'b100000, 1'b1);

    // Back-to-back operands: 10-4, -7-8, 20-(-20)
    step(1'b0, 6'd10, 6'd4);          check("b2b_0", 6'd6,      1'b0);
    step(1'b0, 6'b111001, 6'd8);      check("b2b_1", 6'b110001, 1'b0);
    step(1'b0, 6'd20, 6'b101100);     check("b2b_2", 6'b101000, 1'b1);

    // Exhaustive sweep with a one-edge reset injected mid-stream
    for (int i = 0; i < (1 << W); i++) begin
      for (int j = 0; j < (1 << W); j++) begin
        if (i == 21 && j == 7) begin
          step(1'b1, 6'd31, 6'b100000);
          check("mid_reset", 6'd0, 1'b0);
        end
        ra = i[W-1:0];
        rb = j[W-1:0];
        run_model("sweep", ra, rb);
      end
    end

    // Randomised pairs, including random reset pulses
    for (int k = 0; k < 300; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        step(1'b1, ra, rb);
        check("rand_reset", 6'd0, 1'b0);
      end else begin
        run_model("random", ra, rb);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

`default_nettype wire
